mp_add_seq: RTL and testbench

Multi-precision add sequencer. It time-multiplexes one WIDTH-bit ripple-carry adder (rc_adder) across WORDS slices of a WORDS*WIDTH-bit operand pair, least-significant slice first. The inter-slice carry is held in a register. Sits between an operand producer and a result consumer, with valid/ready handshakes on both sides. It replaces a wide combinational adder where area matters more than latency.

---
 rtl/mp_add_seq_pkg.sv | 15 +
 rtl/mp_add_seq_rc_adder.sv | 23 ++
 rtl/mp_add_seq.sv | 122 ++++++++++++
 tb/tb_mp_add_seq.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/mp_add_seq_pkg.sv
// Shared types and helpers for the multi-precision add sequencer.
package mp_add_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Slice index width; a single-slice build still needs a 1-bit index.
  function automatic int idx_width(input int words);
    return (words < 2) ? 1 : $clog2(words);
  endfunction

endpackage

// File: rtl/mp_add_seq_rc_adder.sv
// rc_adder: plain WIDTH-bit ripple-carry adder shared by the sequencer.
module rc_adder #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] c;

  assign c[0] = cin;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_fa
    assign sum[gi]  = a[gi] ^ b[gi] ^ c[gi];
    assign c[gi+1]  = (a[gi] & b[gi]) | (c[gi] & (a[gi] ^ b[gi]));
  end

  assign cout = c[WIDTH];

endmodule

// File: rtl/mp_add_seq.sv
// Multi-precision add sequencer: one WIDTH-bit adder walks WORDS slices, LSB first.
// Optional subtract mode is enabled by defining MP_ADD_SEQ_SUB_EN.
module mp_add_seq
  import mp_add_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int WORDS = 4
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH*WORDS-1:0] first_term,
  input  logic [WIDTH*WORDS-1:0] second_term,
  input  logic                   carry_in,
`ifdef MP_ADD_SEQ_SUB_EN
  input  logic                   sub,
`endif
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH*WORDS-1:0] sum_out,
  output logic                   carry_out,
  output logic                   busy
);

  localparam int OPW = WIDTH * WORDS;
  localparam int IW  = idx_width(WORDS);
  localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

  state_t           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [OPW-1:0]   a_q, a_d;
  logic [OPW-1:0]   b_q, b_d;
  logic [OPW-1:0]   sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;

  logic [WIDTH-1:0] a_slice, b_slice, add_sum;
  logic             add_cout;

  assign a_slice = a_q[int'(idx_q)*WIDTH +: WIDTH];
  assign b_slice = b_q[int'(idx_q)*WIDTH +: WIDTH];

  rc_adder #(.WIDTH(WIDTH)) u_rc_adder (
    .a    (a_slice),
    .b    (b_slice),
    .cin  (carry_q),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = first_term;
          b_d     = second_term;
          carry_d = carry_in;
`ifdef MP_ADD_SEQ_SUB_EN
          // A - B == A + ~B + 1
          if (sub) begin
            b_d     = ~second_term;
            carry_d = 1'b1;
          end
`endif
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[int'(idx_q)*WIDTH +: WIDTH] = add_sum;
        carry_d = add_cout;
        if (idx_q == LAST_IDX) begin
          cout_d  = add_cout;
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
    end
  end

  // Status outputs decode the registered state only.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == RUN);
  assign sum_out   = sum_q;
  assign carry_out = cout_q;

endmodule

// File: tb/tb_mp_add_seq.sv
// Bench for mp_add_seq: random and directed operations against an arithmetic reference.
module tb_mp_add_seq;

  localparam int WIDTH = 8;
  localparam int WORDS = 4;
  localparam int OPW   = WIDTH * WORDS;

  logic           clk = 1'b0;
  logic           resetn;
  logic           in_valid, in_ready, carry_in, out_valid, out_ready, carry_out, busy;
  logic [OPW-1:0] first_term, second_term, sum_out;
`ifdef MP_ADD_SEQ_SUB_EN
  logic           sub_sig;
  logic           sub1 = 1'b0;
`endif

  logic           in_valid1, in_ready1, cin1, out_valid1, out_ready1, c1, busy1;
  logic [7:0]     a1, b1, s1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mp_add_seq #(.WIDTH(WIDTH), .WORDS(WORDS)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .first_term (first_term),
    .second_term(second_term),
    .carry_in   (carry_in),
`ifdef MP_ADD_SEQ_SUB_EN
    .sub        (sub_sig),
`endif
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .sum_out    (sum_out),
    .carry_out  (carry_out),
    .busy       (busy)
  );

  mp_add_seq #(.WIDTH(8), .WORDS(1)) dut1 (
    .clk        (clk),
    .resetn     (resetn),
    .in_valid   (in_valid1),
    .in_ready   (in_ready1),
    .first_term (a1),
    .second_term(b1),
    .carry_in   (cin1),
`ifdef MP_ADD_SEQ_SUB_EN
    .sub        (sub1),
`endif
    .out_valid  (out_valid1),
    .out_ready  (out_ready1),
    .sum_out    (s1),
    .carry_out  (c1),
    .busy       (busy1)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: an accepted operation produces the full-width sum WORDS edges later
  // and stays presented until the consumer takes it.
  logic          m_pending;
  int            m_cnt;
  logic [OPW:0]  m_exp;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_pending <= 1'b0;
      m_cnt     <= 0;
    end else if (!m_pending) begin
      if (in_valid) begin
        m_pending <= 1'b1;
        m_cnt     <= 0;
`ifdef MP_ADD_SEQ_SUB_EN
        if (sub_sig)
          m_exp <= {1'b0, first_term} + {1'b0, ~second_term} + 33'd1;
        else
`endif
          m_exp <= {1'b0, first_term} + {1'b0, second_term} + {32'd0, carry_in};
      end
    end else if (m_cnt < WORDS) begin
      m_cnt <= m_cnt + 1;
    end else if (out_ready) begin
      m_pending <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (resetn) begin
      chk("in_ready", in_ready, !m_pending);
      chk("busy", busy, m_pending && (m_cnt < WORDS));
      chk("out_valid", out_valid, m_pending && (m_cnt >= WORDS));
      if (m_pending && (m_cnt >= WORDS)) begin
        chk("sum_out", sum_out, m_exp[OPW-1:0]);
        chk("carry_out", carry_out, m_exp[OPW]);
      end
    end
  end

  task automatic do_op(input logic [OPW-1:0] a, input logic [OPW-1:0] b, input logic c,
                       input logic s, input int hold, input logic lit,
                       input logic [OPW-1:0] exp_s, input logic exp_c);
    int guard = 0;
    int lat;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    in_valid    = 1'b1;
    first_term  = a;
    second_term = b;
    carry_in    = c;
`ifdef MP_ADD_SEQ_SUB_EN
    sub_sig     = s;
`else
    if (s) $display("note: subtract requested on an add-only build");
`endif
    @(negedge clk);
    in_valid    = 1'b0;
    first_term  = $urandom;
    second_term = $urandom;
    carry_in    = 1'($urandom_range(0, 1));
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, WORDS + 1);
    if (lit) begin
      chk("lit_sum", sum_out, exp_s);
      chk("lit_carry", carry_out, exp_c);
    end
    for (int i = 0; i < hold; i++) begin
      in_valid    = 1'($urandom_range(0, 1));
      first_term  = $urandom;
      second_term = $urandom;
      @(negedge clk);
      if (lit) chk("hold_sum", sum_out, exp_s);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    $display("op a=%h b=%h cin=%0d sub=%0d hold=%0d latency=%0d", a, b, c, s, hold, lat);
  endtask

  initial begin
    int lat;
    resetn = 1'b0; in_valid = 1'b0; out_ready = 1'b0; carry_in = 1'b0;
    first_term = '0; second_term = '0;
`ifdef MP_ADD_SEQ_SUB_EN
    sub_sig = 1'b0;
`endif
    in_valid1 = 1'b0; out_ready1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
    #12;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_sum", sum_out, '0);
    chk("rst_carry", carry_out, 1'b0);
    @(negedge clk);
    resetn = 1'b1;
    #1 chk("rst_in_ready", in_ready, 1'b1);
    @(negedge clk);

    do_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 0, 1'b1, 32'h0000_0100, 1'b0);
    do_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 1, 1'b1, 32'h0000_0000, 1'b1);
    do_op(32'hDEAD_BEEF, 32'h1234_5678, 1'b1, 1'b0, 10, 1'b1, 32'hF0E2_1568, 1'b0);

    // Abort an operation at slice 2.
    in_valid = 1'b1; first_term = 32'hAAAA_AAAA; second_term = 32'h5555_5555; carry_in = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1 resetn = 1'b0;
    #1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_out_valid", out_valid, 1'b0);
    chk("abort_sum", sum_out, '0);
    chk("abort_carry", carry_out, 1'b0);
    chk("abort_in_ready", in_ready, 1'b1);
    @(negedge clk);
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    do_op(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 0, 1'b1, 32'h2345_6789, 1'b0);

    for (int n = 0; n < 40; n++)
      do_op($urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0,
            int'($urandom_range(0, 3)), 1'b0, '0, 1'b0);

`ifdef MP_ADD_SEQ_SUB_EN
    do_op(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 0, 1'b1, 32'hFFFF_FFFE, 1'b0);
    do_op(32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1, 0, 1'b1, 32'h0000_0002, 1'b1);
    for (int n = 0; n < 10; n++)
      do_op($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            int'($urandom_range(0, 2)), 1'b0, '0, 1'b0);
`endif

    // Single-slice instance.
    in_valid1 = 1'b1; a1 = 8'h80; b1 = 8'h80; cin1 = 1'b0;
    @(negedge clk);
    in_valid1 = 1'b0; a1 = 8'h13; b1 = 8'h07;
    lat = 1;
    while (!out_valid1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("w1_latency", lat, 2);
    chk("w1_sum", s1, 8'h00);
    chk("w1_carry", c1, 1'b1);
    out_ready1 = 1'b1;
    @(negedge clk);
    out_ready1 = 1'b0;
    chk("w1_out_valid_drop", out_valid1, 1'b0);
    chk("w1_in_ready", in_ready1, 1'b1);
    $display("op w1 a=80 b=80 cin=0 latency=%0d sum=%h carry=%0d", lat, s1, c1);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
